// File: rtl/bus_pkg.sv
// bus_pkg: shared types for the 65C02 bus controller slice.
// Access states, bus masters and datapath constants.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    END
  } state_t;

  typedef enum logic {
    CPU,
    DMA
  } master_t;

  localparam logic [7:0] OPEN_BUS_DEF = 8'hFF;
  localparam int WAIT_W = 4;

endpackage

// File: rtl/bus_controller_if.sv
// bus_controller_if: CPU, DMA and memory-side bus signals.
// slave = controller view, master = CPU/DMA/memory environment.
interface bus_controller_if;

  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;

  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_done;
  logic [7:0]  dma_rdata;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wdata_oe;
  logic [7:0]  mem_rdata;
  logic        ram_sel;
  logic        rom_sel;
  logic        io_sel;
  logic        ram_ce_n;
  logic        rom_ce_n;
  logic        io_ce_n;
  logic        oe_n;
  logic        we_n;

  modport slave (
    input  cpu_addr, cpu_we, cpu_dout,
    output cpu_din, cpu_rdy,
    input  dma_req, dma_addr, dma_we, dma_wdata,
    output dma_gnt, dma_done, dma_rdata,
    output mem_addr, mem_wdata, mem_wdata_oe,
    input  mem_rdata, ram_sel, rom_sel, io_sel,
    output ram_ce_n, rom_ce_n, io_ce_n,
    output oe_n, we_n
  );

  modport master (
    output cpu_addr, cpu_we, cpu_dout,
    input  cpu_din, cpu_rdy,
    output dma_req, dma_addr, dma_we, dma_wdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_addr, mem_wdata, mem_wdata_oe,
    output mem_rdata, ram_sel, rom_sel, io_sel,
    input  ram_ce_n, rom_ce_n, io_ce_n,
    input  oe_n, we_n
  );

endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU/DMA grant with a DMA burst limiter.
// Grant is combinational; the burst counter is registered.
module bus_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic dma_req,
  input  logic dma_cpl,
  input  logic cpu_cpl,
  output logic grant_dma
);

  localparam int CW = $clog2(BURST_MAX + 1);

  logic [CW-1:0] burst;

  assign grant_dma = dma_req && (burst < CW'(BURST_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst <= '0;
    end else if (cpu_cpl) begin
      burst <= '0;
    end else if (dma_cpl) begin
      if (burst < CW'(BURST_MAX)) burst <= burst + CW'(1);
    end else if (idle && !dma_req) begin
      burst <= '0;
    end
  end

endmodule

// File: rtl/bus_controller.sv
// bus_controller: sequences every external access for the 65C02,
// sharing the bus between the CPU and one DMA requester.
module bus_controller
  import bus_pkg::*;
#(
  parameter int         RAM_WAIT      = 0,
  parameter int         ROM_WAIT      = 1,
  parameter int         IO_WAIT       = 2,
  parameter int         DMA_BURST_MAX = 4,
  parameter logic [7:0] OPEN_BUS      = OPEN_BUS_DEF
) (
  input logic            CLOCK_IN,
  input logic            RESET,
  bus_controller_if.slave bus
);

  state_t            state;
  master_t           owner;
  logic              acc_we;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_ld;
  logic              ram_q, rom_q, io_q;
  logic              oe_q, we_q, woe_q;
  logic              rdy_q, done_q, gnt_q;
  logic [15:0]       addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        cpu_din_q;
  logic [7:0]        dma_rdata_q;
  logic              grant_dma;
  logic              mapped;
  logic              in_setup;
  logic              in_idle;
  logic              cpu_cpl;
  logic              dma_cpl;

  assign in_idle  = (state == IDLE);
  assign in_setup = (state == SETUP);
  assign cpu_cpl  = (state == END) && (owner == CPU);
  assign dma_cpl  = (state == END) && (owner == DMA);
  assign mapped   = bus.ram_sel | bus.rom_sel | bus.io_sel;

  bus_arbiter #(
    .BURST_MAX(DMA_BURST_MAX)
  ) u_arb (
    .clk      (CLOCK_IN),
    .rst_n    (RESET),
    .idle     (in_idle),
    .dma_req  (bus.dma_req),
    .dma_cpl  (dma_cpl),
    .cpu_cpl  (cpu_cpl),
    .grant_dma(grant_dma)
  );

  always_comb begin
    wait_ld = '0;
    unique case (1'b1)
      bus.ram_sel: wait_ld = WAIT_W'(RAM_WAIT);
      bus.rom_sel: wait_ld = WAIT_W'(ROM_WAIT);
      bus.io_sel:  wait_ld = WAIT_W'(IO_WAIT);
      default:     wait_ld = '0;
    endcase
  end

  always_ff @(posedge CLOCK_IN or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      owner       <= CPU;
      acc_we      <= 1'b0;
      wait_cnt    <= '0;
      ram_q       <= 1'b0;
      rom_q       <= 1'b0;
      io_q        <= 1'b0;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      woe_q       <= 1'b0;
      rdy_q       <= 1'b0;
      done_q      <= 1'b0;
      gnt_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_din_q   <= OPEN_BUS;
      dma_rdata_q <= OPEN_BUS;
    end else begin
      unique case (state)
        IDLE: begin
          owner   <= grant_dma ? DMA : CPU;
          gnt_q   <= grant_dma;
          addr_q  <= grant_dma ? bus.dma_addr : bus.cpu_addr;
          acc_we  <= grant_dma ? bus.dma_we : bus.cpu_we;
          wdata_q <= grant_dma ? bus.dma_wdata : bus.cpu_dout;
          state   <= SETUP;
        end
        SETUP: begin
          ram_q    <= bus.ram_sel;
          rom_q    <= bus.rom_sel;
          io_q     <= bus.io_sel;
          wait_cnt <= wait_ld;
          if (mapped) begin
            woe_q <= acc_we;
            oe_q  <= acc_we;
            we_q  <= !acc_we;
            state <= STROBE;
          end else begin
            // unmapped: reads float to OPEN_BUS, writes vanish
            if (!acc_we) begin
              if (owner == DMA) dma_rdata_q <= OPEN_BUS;
              else              cpu_din_q   <= OPEN_BUS;
            end
            rdy_q  <= (owner == CPU);
            done_q <= (owner == DMA);
            state  <= END;
          end
        end
        STROBE: begin
          if (wait_cnt == '0) begin
            oe_q <= 1'b1;
            we_q <= 1'b1;
            if (!acc_we) begin
              if (owner == DMA) dma_rdata_q <= bus.mem_rdata;
              else              cpu_din_q   <= bus.mem_rdata;
            end
            rdy_q  <= (owner == CPU);
            done_q <= (owner == DMA);
            state  <= END;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        END: begin
          ram_q  <= 1'b0;
          rom_q  <= 1'b0;
          io_q   <= 1'b0;
          woe_q  <= 1'b0;
          rdy_q  <= 1'b0;
          done_q <= 1'b0;
          gnt_q  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // enable goes low in SETUP straight off the decoder, then held registered
  assign bus.ram_ce_n     = ~(ram_q | (in_setup & bus.ram_sel));
  assign bus.rom_ce_n     = ~(rom_q | (in_setup & bus.rom_sel));
  assign bus.io_ce_n      = ~(io_q  | (in_setup & bus.io_sel));
  assign bus.oe_n         = oe_q;
  assign bus.we_n         = we_q;
  assign bus.mem_wdata_oe = woe_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.cpu_din      = cpu_din_q;
  assign bus.cpu_rdy      = rdy_q;
  assign bus.dma_gnt      = gnt_q;
  assign bus.dma_done     = done_q;
  assign bus.dma_rdata    = dma_rdata_q;

endmodule

// File: tb/tb_bus_controller.sv
// tb_bus_controller: directed scenarios for bus_controller
// with default wait states and burst limit.
module tb_bus_controller;

  logic clk;
  logic rst_n;

  bus_controller_if bif();

  bus_controller dut (
    .CLOCK_IN(clk),
    .RESET   (rst_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;
  int clash;

  int          m_ce, m_oe, m_we, m_woe;
  int          m_gnt, m_rdy, m_pulse;
  logic        m_dma;
  logic [7:0]  m_din, m_rdata, m_wdata;
  logic [15:0] m_addr;

  // Observes one access from IDLE up to its completion pulse.
  task automatic measure(input bit skip_idle);
    int lows;
    if (skip_idle) @(negedge clk);
    m_ce = 0; m_oe = 0; m_we = 0; m_woe = 0;
    m_gnt = 0; m_rdy = 0; m_pulse = 0; m_dma = 1'b0;
    m_din = 8'h00; m_rdata = 8'h00;
    m_wdata = 8'h00; m_addr = 16'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      lows = int'(!bif.ram_ce_n) + int'(!bif.rom_ce_n)
           + int'(!bif.io_ce_n);
      if (lows > 1 || (!bif.oe_n && !bif.we_n)) clash++;
      if (lows != 0) m_ce++;
      if (!bif.oe_n) m_oe++;
      if (!bif.we_n) m_we++;
      if (bif.mem_wdata_oe) m_woe++;
      if (bif.dma_gnt) m_gnt++;
      if (bif.cpu_rdy) m_rdy++;
      if (k == 1) m_addr = bif.mem_addr;
      if (k == 2) m_wdata = bif.mem_wdata;
      if (bif.cpu_rdy || bif.dma_done) begin
        m_pulse = k;
        m_dma   = bif.dma_done;
        m_din   = bif.cpu_din;
        m_rdata = bif.dma_rdata;
        break;
      end
    end
  endtask

  task automatic set_sel(input logic ram, rom, io);
    bif.ram_sel = ram;
    bif.rom_sel = rom;
    bif.io_sel  = io;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.cpu_addr = 16'h0; bif.cpu_we = 1'b0;
    bif.cpu_dout = 8'h00; bif.dma_req = 1'b0;
    bif.dma_addr = 16'h0; bif.dma_we = 1'b0;
    bif.dma_wdata = 8'h00; bif.mem_rdata = 8'h00;
    set_sel(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({bif.ram_ce_n, bif.rom_ce_n, bif.io_ce_n,
         bif.oe_n, bif.we_n} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 11111",
        {bif.ram_ce_n, bif.rom_ce_n, bif.io_ce_n,
         bif.oe_n, bif.we_n});
    end
    checks++;
    if ({bif.cpu_rdy, bif.dma_gnt, bif.dma_done,
         bif.mem_wdata_oe} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
        {bif.cpu_rdy, bif.dma_gnt, bif.dma_done,
         bif.mem_wdata_oe});
    end
    checks++;
    if ({bif.mem_addr, bif.mem_wdata} !== 24'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h want 000000",
        {bif.mem_addr, bif.mem_wdata});
    end
    checks++;
    if ({bif.cpu_din, bif.dma_rdata} !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_rdata: got %h want ffff",
        {bif.cpu_din, bif.dma_rdata});
    end
    bif.cpu_addr = 16'h8000;
    rst_n = 1'b1;
  endtask

  task automatic test_unmapped_read();
    measure(1'b0);
    checks++;
    if (m_pulse !== 2 || m_dma !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_rdy: got cyc %0d dma %b want 2 0",
        m_pulse, m_dma);
    end
    checks++;
    if (m_ce + m_oe + m_we !== 0) begin
      errors++;
      $display("FAIL unmapped_strobes: got %0d want 0",
        m_ce + m_oe + m_we);
    end
    checks++;
    if (m_din !== 8'hFF) begin
      errors++;
      $display("FAIL unmapped_din: got %h want ff", m_din);
    end
  endtask

  task automatic test_ram_read();
    bif.cpu_addr = 16'h0010; bif.cpu_we = 1'b0;
    bif.mem_rdata = 8'hA5;
    set_sel(1'b1, 1'b0, 1'b0);
    measure(1'b1);
    checks++;
    if (m_addr !== 16'h0010) begin
      errors++;
      $display("FAIL ram_addr: got %h want 0010", m_addr);
    end
    checks++;
    if (m_ce !== 3 || m_oe !== 1 || m_we !== 0) begin
      errors++;
      $display("FAIL ram_strobes: got ce %0d oe %0d we %0d want 3 1 0",
        m_ce, m_oe, m_we);
    end
    checks++;
    if (m_pulse !== 3 || m_din !== 8'hA5) begin
      errors++;
      $display("FAIL ram_rdy: got cyc %0d din %h want 3 a5",
        m_pulse, m_din);
    end
  endtask

  task automatic test_io_write();
    bif.cpu_addr = 16'hFFFC; bif.cpu_we = 1'b1;
    bif.cpu_dout = 8'h5A; bif.mem_rdata = 8'h11;
    set_sel(1'b0, 1'b0, 1'b1);
    measure(1'b1);
    checks++;
    if (m_we !== 3 || m_oe !== 0 || m_ce !== 5) begin
      errors++;
      $display("FAIL io_strobes: got we %0d oe %0d ce %0d want 3 0 5",
        m_we, m_oe, m_ce);
    end
    checks++;
    if (m_woe !== 4 || m_wdata !== 8'h5A) begin
      errors++;
      $display("FAIL io_wdata: got oe %0d data %h want 4 5a",
        m_woe, m_wdata);
    end
    checks++;
    if (m_pulse !== 5 || m_din !== 8'hA5) begin
      errors++;
      $display("FAIL io_rdy: got cyc %0d din %h want 5 a5",
        m_pulse, m_din);
    end
  endtask

  task automatic test_unmapped_write();
    bif.cpu_addr = 16'h9000; bif.cpu_we = 1'b1;
    set_sel(1'b0, 1'b0, 1'b0);
    measure(1'b1);
    checks++;
    if (m_pulse !== 2 || m_woe !== 0 || m_we !== 0) begin
      errors++;
      $display("FAIL unmapped_wr: got cyc %0d woe %0d we %0d want 2 0 0",
        m_pulse, m_woe, m_we);
    end
  endtask

  task automatic test_dma_burst();
    logic [5:0] seq;
    int         rdy_in_dma;
    seq = '0;
    rdy_in_dma = 0;
    bif.dma_req = 1'b1; bif.dma_addr = 16'h2000;
    bif.dma_we = 1'b0; bif.mem_rdata = 8'h3C;
    set_sel(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      measure(1'b1);
      seq[i] = m_dma;
      if (m_dma) rdy_in_dma += m_rdy;
      if (i == 0) begin
        checks++;
        if (m_addr !== 16'h2000 || m_gnt !== 3) begin
          errors++;
          $display("FAIL dma_grant: got addr %h gnt %0d want 2000 3",
            m_addr, m_gnt);
        end
        checks++;
        if (m_pulse !== 3 || m_rdata !== 8'h3C) begin
          errors++;
          $display("FAIL dma_read: got cyc %0d data %h want 3 3c",
            m_pulse, m_rdata);
        end
      end
    end
    checks++;
    if (seq !== 6'b101111) begin
      errors++;
      $display("FAIL dma_burst_order: got %b want 101111", seq);
    end
    checks++;
    if (rdy_in_dma !== 0) begin
      errors++;
      $display("FAIL dma_cpu_stall: got %0d want 0", rdy_in_dma);
    end
  endtask

  task automatic test_dma_drop();
    int         done_k;
    logic       gnt;
    logic [7:0] rd;
    done_k = 0; gnt = 1'b0; rd = 8'h00;
    bif.mem_rdata = 8'h77;
    bif.cpu_addr = 16'hE000; bif.cpu_we = 1'b0;
    set_sel(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) bif.dma_req = 1'b0;
      if (bif.dma_done) begin
        done_k = k; gnt = bif.dma_gnt; rd = bif.dma_rdata;
        break;
      end
    end
    checks++;
    if (done_k !== 4 || gnt !== 1'b1 || rd !== 8'h77) begin
      errors++;
      $display("FAIL dma_drop_done: got cyc %0d gnt %b data %h want 4 1 77",
        done_k, gnt, rd);
    end
    measure(1'b1);
    checks++;
    if (m_dma !== 1'b0 || m_pulse !== 4 || m_din !== 8'h77) begin
      errors++;
      $display("FAIL dma_drop_cpu: got dma %b cyc %0d din %h want 0 4 77",
        m_dma, m_pulse, m_din);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    bif.mem_rdata = 8'h42;
    repeat (3) @(negedge clk);
    checks++;
    if ({bif.rom_ce_n, bif.oe_n} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_pre: got %b want 00",
        {bif.rom_ce_n, bif.oe_n});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.rom_ce_n, bif.oe_n, bif.cpu_rdy} !== 3'b110) begin
      errors++;
      $display("FAIL rst_mid_async: got %b want 110",
        {bif.rom_ce_n, bif.oe_n, bif.cpu_rdy});
    end
    repeat (3) begin
      @(negedge clk);
      if (bif.cpu_rdy || !bif.rom_ce_n) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL rst_mid_hold: got %0d want 0", stray);
    end
    rst_n = 1'b1;
    measure(1'b0);
    checks++;
    if (m_pulse !== 4 || m_din !== 8'h42) begin
      errors++;
      $display("FAIL rst_mid_restart: got cyc %0d din %h want 4 42",
        m_pulse, m_din);
    end
    checks++;
    if (m_ce !== 4 || m_oe !== 2) begin
      errors++;
      $display("FAIL rom_strobes: got ce %0d oe %0d want 4 2",
        m_ce, m_oe);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (clash !== 0) begin
      errors++;
      $display("FAIL exclusive: got %0d want 0", clash);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clash  = 0;
    test_reset();
    test_unmapped_read();
    test_ram_read();
    test_io_write();
    test_unmapped_write();
    test_dma_burst();
    test_dma_drop();
    test_reset_mid();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
